// File: rtl/nios_led_nios2_qsys_0_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port OCI debug RAM between JTAG debug commands
// and the CPU debug-mode Avalon slave; one access in flight, always returning through IDLE.
module nios_led_nios2_qsys_0_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [37:0]         jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  output logic [31:0]         MonDReg,
  output logic                jtag_busy,
  output logic                jtag_overrun,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [DATA_W-1:0]   cpu_writedata,
  input  logic [DATA_W/8-1:0] cpu_byteenable,
  input  logic                cpu_debugaccess,
  output logic [DATA_W-1:0]   cpu_readdata,
  output logic                cpu_waitrequest,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_wren,
  output logic [DATA_W/8-1:0] ram_byteen,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR      = 2'd1;
  localparam logic [1:0] S_RD_ADDR = 2'd2;
  localparam logic [1:0] S_RD_DATA = 2'd3;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_JTAG = 1'b1;

  logic [1:0]          state;
  logic                owner;
  logic                last_grant;
  logic                jtag_pend;
  logic                jtag_op_wr;
  logic                jtag_aload;
  logic [ADDR_W-1:0]   jtag_addr;
  logic [DATA_W-1:0]   jtag_wdata;
  logic                acc_wr_ok;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [DATA_W/8-1:0] acc_be;

  logic cpu_req;
  logic jtag_strobe;
  logic grant_any;
  logic grant_jtag;
  logic next_wr;
  logic jdo_unused;

  assign cpu_req     = cpu_read | cpu_write;
  assign jtag_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign jtag_busy   = jtag_pend | ((owner == OWN_JTAG) && (state != S_IDLE));
  assign jdo_unused  = ^{jdo[37:36], jdo[2:0]};

  // On contention the side that did not win last time gets the RAM.
  always_comb begin
    grant_jtag = jtag_pend;
    if (jtag_pend && cpu_req) grant_jtag = (last_grant == OWN_CPU);
  end

  assign grant_any = (state == S_IDLE) && (jtag_pend || cpu_req);
  assign next_wr   = grant_jtag ? jtag_op_wr : cpu_write;

  assign ram_addr        = acc_addr;
  assign ram_wdata       = acc_wdata;
  assign ram_byteen      = acc_be;
  assign ram_wren        = (state == S_WR) && acc_wr_ok;
  assign cpu_readdata    = ram_rdata;
  assign cpu_waitrequest = cpu_req & ~((owner == OWN_CPU) && ((state == S_WR) || (state == S_RD_DATA)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      owner        <= OWN_CPU;
      last_grant   <= OWN_CPU;
      jtag_pend    <= 1'b0;
      jtag_op_wr   <= 1'b0;
      jtag_aload   <= 1'b0;
      jtag_addr    <= '0;
      MonDReg      <= '0;
      jtag_overrun <= 1'b0;
      acc_wr_ok    <= 1'b0;
    end else begin
      // JTAG capture: strobes arriving while busy are dropped whole and flagged
      if (jtag_strobe) begin
        if (jtag_busy) begin
          jtag_overrun <= 1'b1;
        end else if (take_action_ocimem_b) begin
          jtag_pend  <= 1'b1;
          jtag_op_wr <= 1'b1;
          jtag_aload <= 1'b0;
        end else if (take_action_ocimem_a) begin
          jtag_addr    <= jdo[ADDR_W+16:17];
          jtag_overrun <= 1'b0;
          jtag_pend    <= jdo[35];
          jtag_op_wr   <= 1'b0;
          jtag_aload   <= 1'b1;
        end else begin
          jtag_pend  <= 1'b1;
          jtag_op_wr <= 1'b0;
          jtag_aload <= 1'b0;
        end
      end

      // Access FSM
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner      <= grant_jtag;
            last_grant <= grant_jtag;
            acc_wr_ok  <= grant_jtag | cpu_debugaccess;
            state      <= next_wr ? S_WR : S_RD_ADDR;
          end
        end
        S_WR: begin
          if (owner == OWN_JTAG) begin
            jtag_addr <= jtag_addr + 1'b1;
            jtag_pend <= 1'b0;
          end
          state <= S_IDLE;
        end
        S_RD_ADDR: state <= S_RD_DATA;
        default: begin
          if (owner == OWN_JTAG) begin
            MonDReg <= 32'(ram_rdata);
            if (!jtag_aload) jtag_addr <= jtag_addr + 1'b1;
            jtag_pend <= 1'b0;
          end
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath latches: no reset, only qualified by capture/grant
  always_ff @(posedge clk) begin
    if (take_action_ocimem_b && !jtag_busy) jtag_wdata <= DATA_W'(jdo[34:3]);
    if (grant_any) begin
      acc_addr  <= grant_jtag ? jtag_addr : cpu_address;
      acc_wdata <= grant_jtag ? jtag_wdata : cpu_writedata;
      acc_be    <= grant_jtag ? '1 : cpu_byteenable;
    end
  end

endmodule
